// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding, tick divider derivation
// and the default clock/tick rates used by the control, counter and display blocks.
package stopwatch_pkg;

   localparam int DEFAULT_CLK_HZ  = 100_000_000;
   localparam int DEFAULT_TICK_HZ = 100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_LAP   = 2'b11
   } sw_state_e;

   // Clocks per count tick; callers must pick rates giving an exact integer >= 2.
   function automatic int calc_div(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Bundle between the button synchronizers / time datapath and the stopwatch control FSM.
// Buttons are synchronized levels; all FSM-side signals are registered, no handshake.
interface stopwatch_if;
   import stopwatch_pkg::*;

   logic      btn_start;
   logic      btn_lap;
   logic      btn_clear;
   logic      tick;
   logic      count_clr;
   logic      disp_live;
   logic      running;
   sw_state_e state;

   modport master (
      output btn_start, btn_lap, btn_clear,
      input  tick, count_clr, disp_live, running, state
   );

   modport slave (
      input  btn_start, btn_lap, btn_clear,
      output tick, count_clr, disp_live, running, state
   );

endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector for one synchronized button level. Reset loads prev=1 so a
// button held through reset must be released and pressed again to register.
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic rise
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = level;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign rise = level & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button events drive IDLE/RUN/PAUSE/LAP, a prescaler makes the
// count tick, and registered outputs steer the counter clear and display freeze.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ  = DEFAULT_CLK_HZ,
   parameter int TICK_HZ = DEFAULT_TICK_HZ
) (
   input  logic        clk,
   input  logic        reset,
   stopwatch_if.slave  bus
);

   localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   logic start_ev;
   logic lap_ev;
   logic clear_ev;

   rise_detect u_rise_start (.clk(clk), .reset(reset), .level(bus.btn_start), .rise(start_ev));
   rise_detect u_rise_lap   (.clk(clk), .reset(reset), .level(bus.btn_lap),   .rise(lap_ev));
   rise_detect u_rise_clear (.clk(clk), .reset(reset), .level(bus.btn_clear), .rise(clear_ev));

   sw_state_e       state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic            tick_q, tick_d;
   logic            clr_q, clr_d;
   logic            live_q, live_d;
   logic            running_q, running_d;
   logic            counting;

   always_comb begin
      state_d   = state_q;
      clr_d     = 1'b0;
      presc_d   = presc_q;
      tick_d    = 1'b0;
      counting  = (state_q == ST_RUN) || (state_q == ST_LAP);

      // Only the top-priority event is considered; if it is illegal here it is dropped.
      if (clear_ev) begin
         if (state_q == ST_IDLE) begin
            clr_d = 1'b1;
         end else if (state_q == ST_PAUSE) begin
            state_d = ST_IDLE;
            clr_d   = 1'b1;
         end
      end else if (start_ev) begin
         case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_PAUSE;
            ST_LAP:   state_d = ST_PAUSE;
            ST_PAUSE: state_d = ST_RUN;
            default:  state_d = ST_IDLE;
         endcase
      end else if (lap_ev) begin
         case (state_q)
            ST_RUN:  state_d = ST_LAP;
            ST_LAP:  state_d = ST_RUN;
            default: state_d = state_q;
         endcase
      end

      // Prescaler follows the current state, so a wrap on the exit edge still ticks.
      if (counting) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
      if ((state_q == ST_IDLE) || clr_d) begin
         presc_d = '0;
      end

      running_d = (state_d == ST_RUN) || (state_d == ST_LAP);
      live_d    = (state_d != ST_LAP);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         presc_q   <= '0;
         tick_q    <= 1'b0;
         clr_q     <= 1'b0;
         live_q    <= 1'b1;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         tick_q    <= tick_d;
         clr_q     <= clr_d;
         live_q    <= live_d;
         running_q <= running_d;
      end
   end

   assign bus.tick      = tick_q;
   assign bus.count_clr = clr_q;
   assign bus.disp_live = live_q;
   assign bus.running   = running_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl at DIV=10: vector table, timing sequences
// and random button traffic checked against a cycle-count reference model.
module tb_stopwatch_ctrl;
   import stopwatch_pkg::*;

   localparam int DIV = 10;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

   logic clk = 1'b0;
   logic rst;
   stopwatch_if bus ();

   stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
      .clk(clk),
      .reset(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // reference model: mode plus total running cycles since the last clear
   int       m_mode = M_IDLE;
   int       m_run  = 0;
   logic [2:0] m_prev = 3'b111;
   logic     m_tick = 1'b0;
   logic     m_clr  = 1'b0;

   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];

   typedef struct {
      logic r, s, l, c;
      logic [1:0] st;
      logic clr;
      logic live;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
      end
   endtask

   task automatic model_update(input logic r, input logic s, input logic l, input logic c);
      logic [2:0] lvl;
      logic [2:0] ev;
      bit counting;
      lvl = {c, l, s};
      ev  = lvl & ~m_prev;
      if (r) begin
         m_mode = M_IDLE; m_run = 0; m_tick = 1'b0; m_clr = 1'b0; m_prev = 3'b111;
      end else begin
         m_prev   = lvl;
         counting = (m_mode == M_RUN) || (m_mode == M_LAP);
         if (counting) m_run++;
         m_tick = counting && (m_run % DIV == 0);
         m_clr  = 1'b0;
         if (ev[2]) begin
            if (m_mode == M_IDLE) m_clr = 1'b1;
            else if (m_mode == M_PAUSE) begin m_mode = M_IDLE; m_clr = 1'b1; end
         end else if (ev[0]) begin
            m_mode = counting ? M_PAUSE : M_RUN;
         end else if (ev[1]) begin
            if (m_mode == M_RUN) m_mode = M_LAP;
            else if (m_mode == M_LAP) m_mode = M_RUN;
         end
         if (m_mode == M_IDLE) m_run = 0;
      end
   endtask

   task automatic step(input logic r, input logic s, input logic l, input logic c);
      rst = r; bus.btn_start = s; bus.btn_lap = l; bus.btn_clear = c;
      @(posedge clk);
      cyc++;
      model_update(r, s, l, c);
      #1;
      chk("m_state", bus.state, m_mode);
      chk("m_running", bus.running, (m_mode == M_RUN) || (m_mode == M_LAP));
      chk("m_disp_live", bus.disp_live, m_mode != M_LAP);
      chk("m_tick", bus.tick, m_tick);
      chk("m_count_clr", bus.count_clr, m_clr);
      if (bus.tick === 1'b1) got_q.push_back(cyc);
   endtask

   task automatic run_idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   task automatic add(input logic r, s, l, c, input logic [1:0] st, input logic clr, live);
      vec_t v;
      v.r = r; v.s = s; v.l = l; v.c = c; v.st = st; v.clr = clr; v.live = live;
      tbl.push_back(v);
   endtask

   initial begin
      int t0;
      logic rs, ls, cs;
      rst = 1'b1; bus.btn_start = 1'b0; bus.btn_lap = 1'b0; bus.btn_clear = 1'b0;

      // r s l c | state clr live
      add(1,0,0,0, 2'd0,0,1); add(0,0,0,0, 2'd0,0,1);
      add(0,0,0,1, 2'd0,1,1); add(0,0,0,0, 2'd0,0,1);
      add(0,0,1,0, 2'd0,0,1); add(0,0,0,0, 2'd0,0,1);
      add(0,1,0,0, 2'd1,0,1); add(0,0,0,0, 2'd1,0,1);
      add(0,0,0,1, 2'd1,0,1); add(0,0,0,0, 2'd1,0,1);
      add(0,0,1,0, 2'd3,0,0); add(0,0,0,0, 2'd3,0,0);
      add(0,0,1,0, 2'd1,0,1); add(0,0,0,0, 2'd1,0,1);
      add(0,0,1,0, 2'd3,0,0); add(0,0,0,0, 2'd3,0,0);
      add(0,1,0,0, 2'd2,0,1); add(0,0,0,0, 2'd2,0,1);
      add(0,0,1,0, 2'd2,0,1); add(0,0,0,0, 2'd2,0,1);
      add(0,1,0,1, 2'd0,1,1); add(0,0,0,0, 2'd0,0,1);
      add(0,1,0,0, 2'd1,0,1); add(0,0,0,0, 2'd1,0,1);
      add(0,1,0,0, 2'd2,0,1); add(0,0,0,0, 2'd2,0,1);
      add(0,1,1,0, 2'd1,0,1); add(0,0,0,0, 2'd1,0,1);
      add(0,0,1,0, 2'd3,0,0); add(0,0,0,0, 2'd3,0,0);
      add(0,1,0,1, 2'd3,0,0); add(0,0,0,0, 2'd3,0,0);
      add(1,0,0,0, 2'd0,0,1);
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].r, tbl[i].s, tbl[i].l, tbl[i].c);
         chk($sformatf("tbl_state_%0d", i), bus.state, tbl[i].st);
         chk($sformatf("tbl_clr_%0d", i), bus.count_clr, tbl[i].clr);
         chk($sformatf("tbl_live_%0d", i), bus.disp_live, tbl[i].live);
      end

      // start from IDLE: ticks at +10, +20, +30
      step(0,0,0,0); step(0,1,0,0);
      t0 = cyc;
      chk("start_state", bus.state, 2'd1);
      got_q.delete();
      exp_q.delete();
      exp_q.push_back(t0 + 10); exp_q.push_back(t0 + 20); exp_q.push_back(t0 + 30);
      run_idle(32);
      chk("run_tick_count", got_q.size(), 3);
      while (exp_q.size() > 0 && got_q.size() > 0) chk("run_tick_time", got_q.pop_front(), exp_q.pop_front());

      // lap keeps counting with display frozen
      step(0,0,1,0);
      chk("lap_state", bus.state, 2'd3);
      chk("lap_live", bus.disp_live, 1'b0);
      got_q.delete();
      run_idle(20);
      chk("lap_tick_count", got_q.size(), 2);
      if (got_q.size() >= 2) chk("lap_tick_period", got_q[1] - got_q[0], DIV);
      step(0,0,1,0);
      chk("unlap_state", bus.state, 2'd1);
      chk("unlap_live", bus.disp_live, 1'b1);

      // pause with the prescaler at 6, resume, first tick 4 cycles later
      step(1,0,0,0); step(0,0,0,0); step(0,1,0,0);
      t0 = cyc;
      run_idle(5);
      step(0,1,0,0);
      chk("pause_state", bus.state, 2'd2);
      got_q.delete();
      run_idle(50);
      chk("pause_ticks", got_q.size(), 0);
      step(0,1,0,0);
      t0 = cyc;
      chk("resume_state", bus.state, 2'd1);
      got_q.delete();
      run_idle(12);
      chk("resume_tick_seen", got_q.size() > 0, 1);
      if (got_q.size() > 0) chk("resume_first_tick", got_q[0] - t0, 4);

      // clear from PAUSE, then clear ignored in RUN
      step(0,1,0,0); step(0,0,0,0);
      chk("pause2_state", bus.state, 2'd2);
      step(0,0,0,1);
      chk("clear_state", bus.state, 2'd0);
      chk("clear_pulse", bus.count_clr, 1'b1);
      step(0,0,0,0);
      chk("clear_pulse_width", bus.count_clr, 1'b0);
      step(0,1,0,0);
      t0 = cyc;
      got_q.delete();
      step(0,0,0,0); step(0,0,0,1);
      chk("run_clear_state", bus.state, 2'd1);
      chk("run_clear_pulse", bus.count_clr, 1'b0);
      run_idle(12);
      chk("post_clear_tick_seen", got_q.size() > 0, 1);
      if (got_q.size() > 0) chk("post_clear_first_tick", got_q[0], t0 + 10);

      // all three buttons in PAUSE: clear wins
      step(0,1,0,0); step(0,0,0,0);
      chk("pause3_state", bus.state, 2'd2);
      step(0,1,1,1);
      chk("multi_state", bus.state, 2'd0);
      chk("multi_clr", bus.count_clr, 1'b1);
      step(0,0,0,0);
      chk("multi_clr_width", bus.count_clr, 1'b0);
      chk("multi_no_run", bus.running, 1'b0);

      // start held through reset and after: no event until re-press
      for (int i = 0; i < 3; i++) step(1,1,0,0);
      for (int i = 0; i < 20; i++) begin
         step(0,1,0,0);
         chk("held_state", bus.state, 2'd0);
      end
      step(0,0,0,0); step(0,1,0,0);
      chk("repress_state", bus.state, 2'd1);
      step(0,0,0,0); step(0,0,1,0); step(0,0,0,0);
      chk("pre_reset_lap", bus.state, 2'd3);
      run_idle(4);
      step(1,0,0,0);
      chk("lap_reset_state", bus.state, 2'd0);
      chk("lap_reset_live", bus.disp_live, 1'b1);
      chk("lap_reset_tick", bus.tick, 1'b0);
      chk("lap_reset_running", bus.running, 1'b0);

      // random button traffic against the model
      rs = 1'b0; ls = 1'b0; cs = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) rs = ~rs;
         if ($urandom_range(0, 7) == 0) ls = ~ls;
         if ($urandom_range(0, 15) == 0) cs = ~cs;
         step($urandom_range(0, 299) == 0, rs, ls, cs);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
